decode_hazard_stage: RTL

DECODE_HAZARD_STAGE -- requirements
Module: decode_hazard_stage

---
 rtl/decode_hazard_stage_pkg.sv | 35 +++
 rtl/decode_hazard_stage_control_decoder.sv | 45 ++++
 rtl/decode_hazard_stage.sv | 105 ++++++++++
 3 files changed

// File: rtl/decode_hazard_stage_pkg.sv
// decode_hazard_stage_pkg: shared opcodes, field positions, ALU codes and control bundle
package decode_hazard_stage_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int RA_W_DEF   = 3;
    localparam int INSTR_W    = 16;
    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RS_HI  = 11;
    localparam int RS_LO  = 9;
    localparam int RT_HI  = 8;
    localparam int RT_LO  = 6;
    localparam int RD_HI  = 5;
    localparam int RD_LO  = 3;
    localparam int FN_HI  = 2;
    localparam int FN_LO  = 0;
    localparam int IMM_W  = 6;
    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_ADDI  = 4'd1;
    localparam logic [3:0] OP_LW    = 4'd2;
    localparam logic [3:0] OP_SW    = 4'd3;
    localparam logic [3:0] OP_BEQ   = 4'd4;
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    typedef struct packed {
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                alu_src;
        logic                branch;
        logic                rt_used;
        logic [RA_W_DEF-1:0] dest;
        logic [2:0]          alu_op;
    } ctrl_t;
endpackage

// File: rtl/decode_hazard_stage_control_decoder.sv
// control_decoder: combinational opcode decode into the ID/EX control bundle
module control_decoder
    import decode_hazard_stage_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output ctrl_t              ctrl
);
    logic [3:0] op;
    assign op = instr[OP_HI:OP_LO];
    always_comb begin
        ctrl = '0;
        ctrl.alu_op = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.rt_used   = 1'b1;
                ctrl.dest      = instr[RD_HI:RD_LO];
                ctrl.alu_op    = instr[FN_HI:FN_LO];
            end
            OP_ADDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.dest      = instr[RT_HI:RT_LO];
            end
            OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.dest       = instr[RT_HI:RT_LO];
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.rt_used   = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch  = 1'b1;
                ctrl.rt_used = 1'b1;
                ctrl.alu_op  = ALU_SUB;
            end
            default: ctrl = '0;
        endcase
    end
endmodule

// File: rtl/decode_hazard_stage.sv
// decode_hazard_stage: decode, writeback bypass, load-use stall and ID/EX register
module decode_hazard_stage
    import decode_hazard_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RA_W   = RA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_id_valid,
    input  logic [15:0]       if_id_instr,
    input  logic [DATA_W-1:0] if_id_pc,
    output logic [RA_W-1:0]   rf_read_reg_1,
    output logic [RA_W-1:0]   rf_read_reg_2,
    input  logic [DATA_W-1:0] rf_read_data_1,
    input  logic [DATA_W-1:0] rf_read_data_2,
    input  logic              wb_reg_write,
    input  logic [RA_W-1:0]   wb_write_reg,
    input  logic [DATA_W-1:0] wb_write_data,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_alu_src,
    output logic              ex_branch,
    output logic [2:0]        ex_alu_op,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [RA_W-1:0]   ex_rs,
    output logic [RA_W-1:0]   ex_rt,
    output logic [RA_W-1:0]   ex_dest,
    output logic [15:0]       stall_count
);
    ctrl_t             ctrl;
    ctrl_t             c;
    logic [RA_W-1:0]   rs;
    logic [RA_W-1:0]   rt;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic              hazard;
    logic              bubble;
    control_decoder u_dec (
        .instr(if_id_instr),
        .ctrl (ctrl)
    );
    assign rs            = if_id_instr[RS_HI:RS_LO];
    assign rt            = if_id_instr[RT_HI:RT_LO];
    assign rf_read_reg_1 = rs;
    assign rf_read_reg_2 = rt;
    assign rs_data = (wb_reg_write && wb_write_reg != '0 && wb_write_reg == rs) ? wb_write_data : rf_read_data_1;
    assign rt_data = (wb_reg_write && wb_write_reg != '0 && wb_write_reg == rt) ? wb_write_data : rf_read_data_2;
    assign imm     = {{(DATA_W-IMM_W){if_id_instr[IMM_W-1]}}, if_id_instr[IMM_W-1:0]};
    assign c       = if_id_valid ? ctrl : '0;
    assign hazard  = if_id_valid && ex_valid && ex_mem_read && ex_dest != '0 &&
                     (ex_dest == rs || (ctrl.rt_used && ex_dest == rt));
    assign stall   = hazard && !flush;
    assign bubble  = rst || flush || stall;
    always_ff @(posedge clk) begin
        if (bubble) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_branch     <= 1'b0;
            ex_alu_op     <= '0;
            ex_pc         <= '0;
            ex_rs_data    <= '0;
            ex_rt_data    <= '0;
            ex_imm        <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_dest       <= '0;
        end else begin
            ex_valid      <= if_id_valid;
            ex_reg_write  <= c.reg_write;
            ex_mem_read   <= c.mem_read;
            ex_mem_write  <= c.mem_write;
            ex_mem_to_reg <= c.mem_to_reg;
            ex_alu_src    <= c.alu_src;
            ex_branch     <= c.branch;
            ex_alu_op     <= c.alu_op;
            ex_pc         <= if_id_pc;
            ex_rs_data    <= rs_data;
            ex_rt_data    <= rt_data;
            ex_imm        <= imm;
            ex_rs         <= rs;
            ex_rt         <= rt;
            ex_dest       <= c.dest;
        end
    end
    always_ff @(posedge clk) begin
        if (rst)
            stall_count <= '0;
        else if (stall && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
    end
endmodule
